pwm_compare_dt: RTL

Compare-and-deadtime stage that sits directly downstream of the PWM carrier generator. It takes the generator's carrier count and compares it against a shadow-buffered compare value to form a reference PWM signal. It then turns that reference into a complementary high-side/low-side gate pair with programmable deadtime. One instance drives one inverter leg; the eight-carrier PWM block instantiates several.

---
 rtl/pwm_compare_dt_pkg.sv | 7 +
 rtl/pwm_compare_dt_if.sv | 17 +
 rtl/pwm_compare_dt_deadtime_gen.sv | 54 +++++
 rtl/pwm_compare_dt.sv | 44 ++++
 4 files changed

// File: rtl/pwm_compare_dt_pkg.sv
// pwm_compare_dt_pkg: shared PWM widths and enums for the compare/deadtime stage
package pwm_compare_dt_pkg;
  localparam int PWMCOUNT_WIDTH = 16;
  typedef enum logic {PWM_OFF = 1'b0, PWM_ON = 1'b1} _pwm_onoff;
  typedef enum logic [1:0] {LOAD_ZERO, LOAD_PERIOD, LOAD_BOTH, LOAD_IMMEDIATE} _load_mode;
  typedef enum logic [2:0] {S_OFF, S_HIGH, S_LOW, S_DT_HL, S_DT_LH} _dt_state;
endpackage

// File: rtl/pwm_compare_dt_if.sv
// pwm_compare_dt_if: carrier/compare/config inputs and gate outputs of one inverter leg
interface pwm_compare_dt_if #(parameter int DT_WIDTH = 10);
  import pwm_compare_dt_pkg::*;
  logic [PWMCOUNT_WIDTH-1:0] carrier;
  logic [PWMCOUNT_WIDTH-1:0] period;
  logic [PWMCOUNT_WIDTH-1:0] compare;
  _load_mode load_mode;
  _pwm_onoff pwm_onoff;
  logic [DT_WIDTH-1:0] deadtime;
  logic pwm_h;
  logic pwm_l;
  logic load_event;
  modport master (output carrier, period, compare, load_mode, pwm_onoff, deadtime,
                  input pwm_h, pwm_l, load_event);
  modport slave (input carrier, period, compare, load_mode, pwm_onoff, deadtime,
                 output pwm_h, pwm_l, load_event);
endinterface

// File: rtl/pwm_compare_dt_deadtime_gen.sv
// deadtime_gen: turns the reference PWM into a complementary gate pair with dead interval
module deadtime_gen import pwm_compare_dt_pkg::*; #(
  parameter int DT_WIDTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ref_i,
  input  _pwm_onoff           pwm_onoff_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
  output logic                pwm_h_o,
  output logic                pwm_l_o
);
  _dt_state state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic h_q, h_d, l_q, l_d;
  logic dz, last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
    end
  end
  // a reference flip back during a dead interval returns to the previous side
  always_comb begin
    dz = deadtime_i == '0;
    last = cnt_q == DT_WIDTH'(1);
    state_d = state_q;
    case (state_q)
      S_OFF:   state_d = ref_i ? (dz ? S_HIGH : S_DT_LH) : (dz ? S_LOW : S_DT_HL);
      S_HIGH:  state_d = ref_i ? S_HIGH : (dz ? S_LOW : S_DT_HL);
      S_LOW:   state_d = ref_i ? (dz ? S_HIGH : S_DT_LH) : S_LOW;
      S_DT_HL: state_d = ref_i ? S_HIGH : (last ? S_LOW : S_DT_HL);
      S_DT_LH: state_d = !ref_i ? S_LOW : (last ? S_HIGH : S_DT_LH);
      default: state_d = S_OFF;
    endcase
    if (pwm_onoff_i == PWM_OFF) state_d = S_OFF;
  end
  always_comb begin
    h_d = state_d == S_HIGH;
    l_d = state_d == S_LOW;
    cnt_d = (state_d == S_DT_HL || state_d == S_DT_LH)
          ? ((state_d != state_q) ? deadtime_i : cnt_q - DT_WIDTH'(1))
          : cnt_q;
  end
  assign pwm_h_o = h_q;
  assign pwm_l_o = l_q;
endmodule

// File: rtl/pwm_compare_dt.sv
// pwm_compare_dt: shadow-buffered carrier compare feeding a deadtime gate pair
module pwm_compare_dt import pwm_compare_dt_pkg::*; #(
  parameter int DT_WIDTH = 10
) (
  input logic              clk,
  input logic              reset,
  pwm_compare_dt_if.slave  pwm_if
);
  logic [PWMCOUNT_WIDTH-1:0] cmp_q, cmp_d;
  logic ref_q, ref_d, ld_q, ld_d;
  logic zero_ev, per_ev;
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q <= '0;
      ref_q <= 1'b0;
      ld_q  <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      ref_q <= ref_d;
      ld_q  <= ld_d;
    end
  end
  // compare uses the pre-load shadow value so a load never affects its own cycle
  always_comb begin
    zero_ev = pwm_if.carrier == '0;
    per_ev = pwm_if.carrier == pwm_if.period;
    ld_d = pwm_if.load_mode == LOAD_IMMEDIATE ? 1'b1
         : pwm_if.load_mode == LOAD_ZERO ? zero_ev
         : pwm_if.load_mode == LOAD_PERIOD ? per_ev
         : (zero_ev | per_ev);
    cmp_d = ld_d ? pwm_if.compare : cmp_q;
    ref_d = pwm_if.carrier < cmp_q;
  end
  deadtime_gen #(.DT_WIDTH(DT_WIDTH)) u_dt (
    .clk         (clk),
    .reset       (reset),
    .ref_i       (ref_q),
    .pwm_onoff_i (pwm_if.pwm_onoff),
    .deadtime_i  (pwm_if.deadtime),
    .pwm_h_o     (pwm_if.pwm_h),
    .pwm_l_o     (pwm_if.pwm_l)
  );
  assign pwm_if.load_event = ld_q;
endmodule
